// File: rtl/maze_map_pkg.sv
// Shared constants for the maze world store: screen geometry, tile geometry,
// colours and the fixed wall/path layout (1 = wall, 0 = path).
package maze_map_pkg;

   localparam int SCREEN_W   = 640;
   localparam int SCREEN_H   = 480;
   localparam int ADDR_W     = 10;
   localparam int TILE_SHIFT = 4;
   localparam int MAP_COLS   = SCREEN_W >> TILE_SHIFT;
   localparam int MAP_ROWS   = SCREEN_H >> TILE_SHIFT;

   localparam logic [ADDR_W-1:0] COL_LIMIT = ADDR_W'(SCREEN_W);
   localparam logic [ADDR_W-1:0] ROW_LIMIT = ADDR_W'(SCREEN_H);

   localparam logic [7:0] PATH_PX = 8'hBF;
   localparam logic [7:0] WALL_PX = 8'h49;
   localparam logic [7:0] GOAL_PX = 8'hE0;
   localparam int         GOAL_COL = 1;
   localparam int         GOAL_ROW = 1;

   // Row patterns, read left to right as tile column 0..39.
   localparam logic [0:MAP_COLS-1] ROW_WALL  = 40'b1111111111_1111111111_1111111111_1111111111;
   localparam logic [0:MAP_COLS-1] ROW_OPEN  = 40'b1000000000_0000000000_0000000000_0000000001;
   localparam logic [0:MAP_COLS-1] ROW_GAP_A = 40'b1011111111_1111011111_1111111110_1111111101;
   localparam logic [0:MAP_COLS-1] ROW_GAP_B = 40'b1111110111_1111111111_0111111111_1110111111;

   localparam logic [0:MAP_COLS-1] MAP_LAYOUT [0:MAP_ROWS-1] = '{
      ROW_WALL,   //  0
      ROW_OPEN,   //  1
      ROW_GAP_A,  //  2
      ROW_OPEN,   //  3
      ROW_GAP_B,  //  4
      ROW_OPEN,   //  5
      ROW_GAP_A,  //  6
      ROW_OPEN,   //  7
      ROW_GAP_B,  //  8
      ROW_OPEN,   //  9
      ROW_GAP_A,  // 10
      ROW_OPEN,   // 11
      ROW_GAP_B,  // 12
      ROW_OPEN,   // 13
      ROW_GAP_A,  // 14
      ROW_OPEN,   // 15: ball start corridor
      ROW_GAP_B,  // 16
      ROW_OPEN,   // 17
      ROW_GAP_A,  // 18
      ROW_OPEN,   // 19
      ROW_GAP_B,  // 20
      ROW_OPEN,   // 21
      ROW_GAP_A,  // 22
      ROW_OPEN,   // 23
      ROW_GAP_B,  // 24
      ROW_OPEN,   // 25
      ROW_GAP_A,  // 26
      ROW_OPEN,   // 27
      ROW_GAP_B,  // 28
      ROW_WALL    // 29
   };

endpackage

// File: rtl/maze_map_port.sv
// One 2-stage lookup pipeline: pixel address in, tile colour out.
// Stage 1 registers tile index and out-of-range flag; stage 2 registers colour.
module maze_map_port #(
   parameter int         TILE_SHIFT = maze_map_pkg::TILE_SHIFT,
   parameter int         MAP_COLS   = maze_map_pkg::MAP_COLS,
   parameter int         MAP_ROWS   = maze_map_pkg::MAP_ROWS,
   parameter logic [7:0] PATH_PX    = maze_map_pkg::PATH_PX,
   parameter logic [7:0] WALL_PX    = maze_map_pkg::WALL_PX,
   parameter bit         GOAL_EN    = 1'b0,
   parameter int         GOAL_COL   = maze_map_pkg::GOAL_COL,
   parameter int         GOAL_ROW   = maze_map_pkg::GOAL_ROW,
   parameter logic [7:0] GOAL_PX    = maze_map_pkg::GOAL_PX
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] col_addr,
   input  logic [9:0] row_addr,
   output logic [7:0] px
);
   import maze_map_pkg::*;

   localparam int COL_W = $clog2(MAP_COLS);
   localparam int ROW_W = $clog2(MAP_ROWS);
   localparam logic [COL_W-1:0] GOAL_C = COL_W'(GOAL_COL);
   localparam logic [ROW_W-1:0] GOAL_R = ROW_W'(GOAL_ROW);

   logic             s1_valid;
   logic             s1_oor;
   logic [COL_W-1:0] s1_col;
   logic [ROW_W-1:0] s1_row;
   logic [7:0]       tile_px;

   // NOTE: the out-of-range test runs first, so a truncated row index beyond
   // the layout is never the selected source.
   always_comb begin
      tile_px = PATH_PX;
      if (!s1_valid)
         tile_px = 8'h00;
      else if (s1_oor)
         tile_px = WALL_PX;
      else if (GOAL_EN && (s1_col == GOAL_C) && (s1_row == GOAL_R))
         tile_px = GOAL_PX;
      else if (MAP_LAYOUT[s1_row][s1_col])
         tile_px = WALL_PX;
   end

   // NOTE: sequential state uses non-blocking assignments so both stages
   // advance together on the same edge.
   always_ff @(posedge clk) begin
      if (!reset) begin
         s1_valid <= 1'b0;
         s1_oor   <= 1'b0;
         s1_col   <= '0;
         s1_row   <= '0;
         px       <= 8'h00;
      end else begin
         s1_valid <= 1'b1;
         s1_oor   <= (col_addr >= COL_LIMIT) || (row_addr >= ROW_LIMIT);
         s1_col   <= col_addr[TILE_SHIFT +: COL_W];
         s1_row   <= row_addr[TILE_SHIFT +: ROW_W];
         px       <= tile_px;
      end
   end

endmodule

// File: rtl/maze_map_rom.sv
// Read-only maze world store with two independent 2-cycle read ports.
// Optional macro MAP_GOAL_EN: goal tile returns GOAL_PX on both ports.
module maze_map_rom #(
   parameter int         TILE_SHIFT = maze_map_pkg::TILE_SHIFT,
   parameter int         MAP_COLS   = maze_map_pkg::MAP_COLS,
   parameter int         MAP_ROWS   = maze_map_pkg::MAP_ROWS,
   parameter logic [7:0] PATH_PX    = maze_map_pkg::PATH_PX,
   parameter logic [7:0] WALL_PX    = maze_map_pkg::WALL_PX,
   parameter int         GOAL_COL   = maze_map_pkg::GOAL_COL,
   parameter int         GOAL_ROW   = maze_map_pkg::GOAL_ROW,
   parameter logic [7:0] GOAL_PX    = maze_map_pkg::GOAL_PX
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] a_col_addr,
   input  logic [9:0] a_row_addr,
   output logic [7:0] a_out,
   input  logic [9:0] b_col_addr,
   input  logic [9:0] b_row_addr,
   output logic [7:0] b_out
);

`ifdef MAP_GOAL_EN
   localparam bit GOAL_EN = 1'b1;
`else
   localparam bit GOAL_EN = 1'b0;
`endif

   maze_map_port #(
      .TILE_SHIFT (TILE_SHIFT),
      .MAP_COLS   (MAP_COLS),
      .MAP_ROWS   (MAP_ROWS),
      .PATH_PX    (PATH_PX),
      .WALL_PX    (WALL_PX),
      .GOAL_EN    (GOAL_EN),
      .GOAL_COL   (GOAL_COL),
      .GOAL_ROW   (GOAL_ROW),
      .GOAL_PX    (GOAL_PX)
   ) u_port_a (
      .clk      (clk),
      .reset    (reset),
      .col_addr (a_col_addr),
      .row_addr (a_row_addr),
      .px       (a_out)
   );

   maze_map_port #(
      .TILE_SHIFT (TILE_SHIFT),
      .MAP_COLS   (MAP_COLS),
      .MAP_ROWS   (MAP_ROWS),
      .PATH_PX    (PATH_PX),
      .WALL_PX    (WALL_PX),
      .GOAL_EN    (GOAL_EN),
      .GOAL_COL   (GOAL_COL),
      .GOAL_ROW   (GOAL_ROW),
      .GOAL_PX    (GOAL_PX)
   ) u_port_b (
      .clk      (clk),
      .reset    (reset),
      .col_addr (b_col_addr),
      .row_addr (b_row_addr),
      .px       (b_out)
   );

endmodule

// File: tb/tb_maze_map_rom.sv
// Self-checking bench for maze_map_rom: directed scenarios plus a randomized
// stream checked against a tile-arithmetic reference model.
module tb_maze_map_rom;
   import maze_map_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [9:0] a_col_addr, a_row_addr, b_col_addr, b_row_addr;
   logic [7:0] a_out, b_out;

   int checks   = 0;
   int failures = 0;

   maze_map_rom dut (
      .clk        (clk),
      .reset      (reset),
      .a_col_addr (a_col_addr),
      .a_row_addr (a_row_addr),
      .a_out      (a_out),
      .b_col_addr (b_col_addr),
      .b_row_addr (b_row_addr),
      .b_out      (b_out)
   );

   always #5 clk = ~clk;

   // Colour of a pixel computed directly from the tile rules.
   function automatic logic [7:0] ref_px(input int col, input int row);
      int tc, tr;
      if (col >= 640 || row >= 480) return 8'h49;
      tc = col / 16;
      tr = row / 16;
`ifdef MAP_GOAL_EN
      if (tc == 1 && tr == 1) return 8'hE0;
`endif
      if (MAP_LAYOUT[tr][tc] == 1'b1) return 8'h49;
      return 8'hBF;
   endfunction

   task automatic drive(input int ac, input int ar, input int bc, input int br);
      @(negedge clk);
      a_col_addr = 10'(ac);
      a_row_addr = 10'(ar);
      b_col_addr = 10'(bc);
      b_row_addr = 10'(br);
   endtask

   // Present an address pair and wait until its result is due.
   task automatic lookup(input int ac, input int ar, input int bc, input int br);
      drive(ac, ar, bc, br);
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive($urandom_range(0, 1023), $urandom_range(0, 1023),
               $urandom_range(0, 1023), $urandom_range(0, 1023));
         @(posedge clk);
         @(negedge clk);
         checks++;
         if (a_out !== 8'h00) begin
            failures++;
            $display("FAIL reset_hold_a cycle=%0d got=%h want=00", i, a_out);
         end
         checks++;
         if (b_out !== 8'h00) begin
            failures++;
            $display("FAIL reset_hold_b cycle=%0d got=%h want=00", i, b_out);
         end
      end
      a_col_addr = 10'd527;
      a_row_addr = 10'd254;
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (a_out === 8'hBF) begin
         failures++;
         $display("FAIL reset_release_1clk got=%h want=not_bf", a_out);
      end
      @(negedge clk);
      checks++;
      if (a_out !== 8'hBF) begin
         failures++;
         $display("FAIL reset_release_2clk got=%h want=bf", a_out);
      end
   endtask

   task automatic test_reset_mid;
      lookup(527, 254, 0, 0);
      drive(0, 0, 527, 254);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (a_out !== 8'h00 || b_out !== 8'h00) begin
         failures++;
         $display("FAIL reset_mid_flush got a=%h b=%h want=00", a_out, b_out);
      end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (b_out === 8'hBF) begin
         failures++;
         $display("FAIL reset_mid_1clk got b=%h want=not_bf", b_out);
      end
      @(negedge clk);
      checks++;
      if (a_out !== 8'h49 || b_out !== 8'hBF) begin
         failures++;
         $display("FAIL reset_mid_resume got a=%h b=%h want a=49 b=bf", a_out, b_out);
      end
   endtask

   task automatic test_border;
      lookup(0, 0, 639, 479);
      checks++;
      if (a_out !== 8'h49) begin
         failures++;
         $display("FAIL border_a_0_0 got=%h want=49", a_out);
      end
      checks++;
      if (b_out !== 8'h49) begin
         failures++;
         $display("FAIL border_b_639_479 got=%h want=49", b_out);
      end
      lookup(8, 250, 320, 0);
      checks++;
      if (a_out !== 8'h49) begin
         failures++;
         $display("FAIL border_a_8_250 got=%h want=49", a_out);
      end
      checks++;
      if (b_out !== 8'h49) begin
         failures++;
         $display("FAIL border_b_320_0 got=%h want=49", b_out);
      end
      // Every tile on the closed border must read as wall.
      for (int t = 0; t < 40; t++) begin
         lookup(t * 16 + 5, 3, t * 16 + 11, 29 * 16 + 7);
         checks++;
         if (a_out !== 8'h49 || b_out !== 8'h49) begin
            failures++;
            $display("FAIL border_row_tile col=%0d got a=%h b=%h want=49", t, a_out, b_out);
         end
      end
      for (int t = 0; t < 30; t++) begin
         lookup(2, t * 16 + 9, 39 * 16 + 14, t * 16);
         checks++;
         if (a_out !== 8'h49 || b_out !== 8'h49) begin
            failures++;
            $display("FAIL border_col_tile row=%0d got a=%h b=%h want=49", t, a_out, b_out);
         end
      end
   endtask

   task automatic test_out_of_range;
      lookup(640, 10, 700, 500);
      checks++;
      if (a_out !== 8'h49 || b_out !== 8'h49) begin
         failures++;
         $display("FAIL oor_640_700 got a=%h b=%h want=49", a_out, b_out);
      end
      lookup(1023, 1023, 527, 254);
      checks++;
      if (a_out !== 8'h49) begin
         failures++;
         $display("FAIL oor_1023 got=%h want=49", a_out);
      end
      checks++;
      if (b_out !== 8'hBF) begin
         failures++;
         $display("FAIL oor_b_start got=%h want=bf", b_out);
      end
      lookup(100, 480, 640, 479);
      checks++;
      if (a_out !== 8'h49 || b_out !== 8'h49) begin
         failures++;
         $display("FAIL oor_edge got a=%h b=%h want=49", a_out, b_out);
      end
   endtask

   task automatic test_pipelining;
      int cols [5] = '{511, 512, 527, 543, 544};
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         if (i >= 2) begin
            checks++;
            if (a_out !== 8'hBF) begin
               failures++;
               $display("FAIL pipe_a col=%0d got=%h want=bf", cols[i-2], a_out);
            end
            checks++;
            if (b_out !== 8'h49) begin
               failures++;
               $display("FAIL pipe_b step=%0d got=%h want=49", i - 2, b_out);
            end
         end
         if (i < 5) begin
            a_col_addr = 10'(cols[i]);
            a_row_addr = 10'd254;
         end else begin
            a_col_addr = 10'd0;
            a_row_addr = 10'd0;
         end
         b_col_addr = 10'd0;
         b_row_addr = 10'd0;
      end
   endtask

   task automatic test_same_addr;
      lookup(527, 254, 527, 254);
      checks++;
      if (a_out !== 8'hBF || b_out !== 8'hBF) begin
         failures++;
         $display("FAIL same_addr got a=%h b=%h want=bf", a_out, b_out);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (a_out !== 8'hBF || b_out !== 8'hBF) begin
         failures++;
         $display("FAIL static_hold got a=%h b=%h want=bf", a_out, b_out);
      end
   endtask

   task automatic test_goal;
      logic [7:0] want;
`ifdef MAP_GOAL_EN
      want = 8'hE0;
`else
      want = 8'hBF;
`endif
      lookup(20, 20, 31, 31);
      checks++;
      if (a_out !== want) begin
         failures++;
         $display("FAIL goal_a got=%h want=%h", a_out, want);
      end
      checks++;
      if (b_out !== want) begin
         failures++;
         $display("FAIL goal_b got=%h want=%h", b_out, want);
      end
      lookup(15, 20, 20, 15);
      checks++;
      if (a_out !== 8'h49 || b_out !== 8'h49) begin
         failures++;
         $display("FAIL goal_neighbour got a=%h b=%h want=49", a_out, b_out);
      end
   endtask

   task automatic test_random;
      logic [7:0] qa [$];
      logic [7:0] qb [$];
      logic [7:0] ea, eb;
      int ac, ar, bc, br;
      for (int i = 0; i < 602; i++) begin
         @(negedge clk);
         if (i >= 2) begin
            ea = qa.pop_front();
            eb = qb.pop_front();
            checks++;
            if (a_out !== ea) begin
               failures++;
               $display("FAIL rand_a step=%0d got=%h want=%h", i, a_out, ea);
            end
            checks++;
            if (b_out !== eb) begin
               failures++;
               $display("FAIL rand_b step=%0d got=%h want=%h", i, b_out, eb);
            end
         end
         if (i < 600) begin
            if ($urandom_range(0, 3) == 0) begin
               ac = $urandom_range(0, 1023); ar = $urandom_range(0, 1023);
               bc = $urandom_range(0, 1023); br = $urandom_range(0, 1023);
            end else begin
               ac = $urandom_range(0, 639); ar = $urandom_range(0, 479);
               bc = $urandom_range(0, 639); br = $urandom_range(0, 479);
            end
            a_col_addr = 10'(ac); a_row_addr = 10'(ar);
            b_col_addr = 10'(bc); b_row_addr = 10'(br);
            qa.push_back(ref_px(ac, ar));
            qb.push_back(ref_px(bc, br));
         end
      end
   endtask

   initial begin
      reset = 1'b0;
      a_col_addr = '0; a_row_addr = '0;
      b_col_addr = '0; b_row_addr = '0;
      test_reset();
      test_border();
      test_out_of_range();
      test_pipelining();
      test_same_addr();
      test_goal();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
